vga_sync_receiver: RTL and testbench

Receive-side VGA timing recovery. Consumes active-low h_sync/v_sync from an external or looped-back 640x480 source, sampled at pixel rate. Rebuilds pixel/line coordinates, qualifies the display area, and declares lock after consistent frames. Sits in front of capture/overlay logic that needs coordinates aligned to an incoming video stream.

---
 rtl/vga_pkg.sv | 27 ++
 rtl/sync_edge_detect.sv | 30 +++
 rtl/vga_sync_receiver.sv | 178 +++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480 timing constants and the lock-state encoding for the VGA sync receiver.
package vga_pkg;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 29;
    localparam int VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // Offsets are measured from the detected sync edge, so they absorb the synchronizer delay.
    localparam int VGA_H_EDGE_TO_ACTIVE = 144;
    localparam int VGA_V_EDGE_TO_ACTIVE = 31;
    localparam int VGA_LOCK_FRAMES      = 2;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } lock_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an active-low sync pin followed by a falling-edge detector,
// all advancing only on pix_en.
module sync_edge_detect (
    input  logic mclk,
    input  logic rst,
    input  logic pix_en,
    input  logic sync_in,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else if (pix_en) begin
            meta_q <= sync_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // Gated by pix_en so the pulse coincides with the strobe that consumes it.
    assign fall = pix_en && prev_q && !sync_q;

endmodule

// File: rtl/vga_sync_receiver.sv
// Recovers pixel/line position from incoming VGA syncs, qualifies the active window and tracks lock.
// Optional statistics (line_len, frame_lines, err_count) are built only when VGA_RX_STATS_EN is defined.
module vga_sync_receiver
    import vga_pkg::*;
#(
    parameter int H_TOTAL          = VGA_H_TOTAL,
    parameter int V_TOTAL          = VGA_V_TOTAL,
    parameter int H_DISPLAY        = VGA_H_DISPLAY,
    parameter int V_DISPLAY        = VGA_V_DISPLAY,
    parameter int H_EDGE_TO_ACTIVE = VGA_H_EDGE_TO_ACTIVE,
    parameter int V_EDGE_TO_ACTIVE = VGA_V_EDGE_TO_ACTIVE,
    parameter int LOCK_FRAMES      = VGA_LOCK_FRAMES
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    output logic [9:0]  rx_h_cnt,
    output logic [9:0]  rx_v_cnt,
    output logic        rx_active,
    output logic        locked,
    output logic        frame_start,
    output logic        sync_err,
    output logic [10:0] line_len,
    output logic [9:0]  frame_lines,
    output logic [7:0]  err_count,
    output lock_state_e lock_state
);

    localparam logic [11:0] H_TOTAL_W = 12'(H_TOTAL);
    localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
    localparam logic [10:0] H_LO      = 11'(H_EDGE_TO_ACTIVE);
    localparam logic [10:0] H_HI      = 11'(H_EDGE_TO_ACTIVE + H_DISPLAY);
    localparam logic [9:0]  V_LO      = 10'(V_EDGE_TO_ACTIVE);
    localparam logic [9:0]  V_HI      = 10'(V_EDGE_TO_ACTIVE + V_DISPLAY);
    localparam logic [3:0]  LOCK_N    = 4'(LOCK_FRAMES);

    logic        h_edge;
    logic        v_edge;
    logic [10:0] hpos, hpos_nxt;
    logic [9:0]  vpos, vpos_nxt;
    logic        vflag, vflag_nxt;
    lock_state_e state, state_nxt;
    logic [3:0]  good_cnt, good_cnt_nxt;
    logic        frame_edge, line_bad, frame_bad, hsat, fail, err_nxt;
    logic        in_area;
    logic [10:0] h_off;
    logic [9:0]  v_off;

    sync_edge_detect u_h_edge (
        .mclk    (mclk),
        .rst     (rst),
        .pix_en  (pix_en),
        .sync_in (h_sync_in),
        .fall    (h_edge)
    );

    sync_edge_detect u_v_edge (
        .mclk    (mclk),
        .rst     (rst),
        .pix_en  (pix_en),
        .sync_in (v_sync_in),
        .fall    (v_edge)
    );

    always_comb begin
        hpos_nxt     = hpos;
        vpos_nxt     = vpos;
        vflag_nxt    = vflag;
        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        frame_edge   = 1'b0;
        line_bad     = 1'b0;
        frame_bad    = 1'b0;
        hsat         = 1'b0;

        if (pix_en) begin
            if (h_edge) begin
                hpos_nxt = '0;
                line_bad = ({1'b0, hpos} + 12'd1) != H_TOTAL_W;
                // A v_sync edge on this same strobe is consumed immediately.
                if (vflag || v_edge) begin
                    frame_edge = 1'b1;
                    frame_bad  = ({1'b0, vpos} + 11'd1) != V_TOTAL_W;
                    vpos_nxt   = '0;
                    vflag_nxt  = 1'b0;
                end else if (vpos != 10'h3FF) begin
                    vpos_nxt = vpos + 10'd1;
                end
            end else begin
                if (v_edge) vflag_nxt = 1'b1;
                if (hpos != 11'h7FF) hpos_nxt = hpos + 11'd1;
                hsat = (hpos == 11'h7FE);
            end
        end

        fail = hsat || line_bad || frame_bad;

        case (state)
            SEARCH: begin
                if (frame_edge) begin
                    state_nxt    = TRACK;
                    good_cnt_nxt = '0;
                end
            end
            TRACK: begin
                if (fail) begin
                    good_cnt_nxt = '0;
                end else if (frame_edge) begin
                    good_cnt_nxt = good_cnt + 4'd1;
                    if (good_cnt + 4'd1 >= LOCK_N) state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (fail) state_nxt = SEARCH;
            end
            default: state_nxt = SEARCH;
        endcase

        err_nxt = (state == LOCKED) && fail;

        in_area = (hpos_nxt >= H_LO) && (hpos_nxt < H_HI) && (vpos_nxt >= V_LO) && (vpos_nxt < V_HI);
        h_off   = hpos_nxt - H_LO;
        v_off   = vpos_nxt - V_LO;
    end

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            hpos        <= '0;
            vpos        <= '0;
            vflag       <= 1'b0;
            state       <= SEARCH;
            good_cnt    <= '0;
            rx_h_cnt    <= '0;
            rx_v_cnt    <= '0;
            rx_active   <= 1'b0;
            locked      <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_nxt;
            good_cnt    <= good_cnt_nxt;
            frame_start <= frame_edge;
            sync_err    <= err_nxt;
            if (pix_en) begin
                hpos      <= hpos_nxt;
                vpos      <= vpos_nxt;
                vflag     <= vflag_nxt;
                rx_h_cnt  <= in_area ? h_off[9:0] : 10'd0;
                rx_v_cnt  <= in_area ? v_off : 10'd0;
                rx_active <= in_area && (state_nxt == LOCKED);
                locked    <= (state_nxt == LOCKED);
            end
        end
    end

    assign lock_state = state;

`ifdef VGA_RX_STATS_EN
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            line_len    <= '0;
            frame_lines <= '0;
            err_count   <= '0;
        end else begin
            if (h_edge) line_len <= hpos + 11'd1;
            if (frame_edge) frame_lines <= vpos + 10'd1;
            if (err_nxt && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
        end
    end
`else
    assign line_len    = '0;
    assign frame_lines = '0;
    assign err_count   = '0;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Self-checking bench for vga_sync_receiver on a scaled-down 40x16 timing so lock fits a short run.
module tb_vga_sync_receiver;
    import vga_pkg::*;

    localparam int HT   = 40;
    localparam int HD   = 24;
    localparam int HE   = 10;
    localparam int VT   = 16;
    localparam int VD   = 10;
    localparam int VE   = 4;
    localparam int LF   = 2;
    localparam int HSW  = 4;
    localparam int VOFF = 20;
    localparam int FRAME = HT * VT;
    localparam int EW   = 25;

    logic        mclk = 1'b0;
    logic        rst = 1'b0;
    logic        pix_en = 1'b0;
    logic        h_sync_in = 1'b1;
    logic        v_sync_in = 1'b1;
    logic [9:0]  rx_h_cnt, rx_v_cnt;
    logic        rx_active, locked, frame_start, sync_err;
    logic [10:0] line_len;
    logic [9:0]  frame_lines;
    logic [7:0]  err_count;
    lock_state_e lock_state;

    vga_sync_receiver #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_DISPLAY(HD), .V_DISPLAY(VD),
        .H_EDGE_TO_ACTIVE(HE), .V_EDGE_TO_ACTIVE(VE), .LOCK_FRAMES(LF)
    ) dut (
        .mclk(mclk), .rst(rst), .pix_en(pix_en), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
        .rx_h_cnt(rx_h_cnt), .rx_v_cnt(rx_v_cnt), .rx_active(rx_active), .locked(locked),
        .frame_start(frame_start), .sync_err(sync_err), .line_len(line_len),
        .frame_lines(frame_lines), .err_count(err_count), .lock_state(lock_state)
    );

    always #5 mclk = ~mclk;

    // Expected word: {coords_valid, frame_start, sync_err, locked, rx_active, rx_v_cnt, rx_h_cnt}
    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Source generator state and the two-strobe history that matches the receiver's edge latency.
    int src_px, src_ln, src_len, voff;
    bit sync_off, next_bad;
    int d1_px, d1_ln, d2_px, d2_ln;
    bit d1_bad, d2_bad;
    int edges;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic v_level(input int px, input int ln, input int vo);
        if (ln < 2) return 1'b0;
        if (vo != 0 && ln == VT - 1 && px >= vo) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_history();
        d1_px = -1; d1_ln = -1; d2_px = -1; d2_ln = -1;
        d1_bad = 1'b0; d2_bad = 1'b0; next_bad = 1'b0;
        edges = 0;
    endtask

    task automatic advance();
        if (sync_off) begin
            src_px++;
        end else if (src_px >= src_len - 1) begin
            next_bad = (src_len != HT);
            src_px = 0;
            src_len = HT;
            if (src_ln == VT - 1) begin
                src_ln = 0;
                voff = (voff == 0) ? VOFF : 0;
            end else begin
                src_ln++;
            end
        end else begin
            src_px++;
        end
    endtask

    task automatic strobe();
        logic [EW-1:0] e;
        logic [EW-1:0] g;
        int dpx, dln;
        bit fe, bad, err, lk, act, cur_bad;
        @(negedge mclk);
        check("pulse_width", {30'd0, frame_start, sync_err}, 32'd0);
        h_sync_in = sync_off || (src_px >= HSW);
        v_sync_in = sync_off || v_level(src_px, src_ln, voff);
        pix_en = 1'b1;
        cur_bad = next_bad;
        next_bad = 1'b0;
        dpx = d2_px;
        dln = d2_ln;
        bad = d2_bad || (dpx == 2047);
        d2_px = d1_px; d2_ln = d1_ln; d2_bad = d1_bad;
        d1_px = src_px; d1_ln = src_ln; d1_bad = cur_bad;
        fe = (dpx == 0) && (dln == 0);
        err = 1'b0;
        if (bad && edges >= 1 + LF) begin
            err = 1'b1;
            edges = 0;
        end else if (bad && edges > 0) begin
            edges = 1;
        end else if (fe && edges < 1 + LF) begin
            edges++;
        end
        lk = (edges >= 1 + LF);
        act = lk && dpx >= HE && dpx < HE + HD && dln >= VE && dln < VE + VD;
        e = {lk, fe, err, lk, act, act ? 10'(dln - VE) : 10'd0, act ? 10'(dpx - HE) : 10'd0};
        exp_q.push_back(e);
        advance();
        @(negedge mclk);
        pix_en = 1'b0;
        g = exp_q.pop_front();
        check("status", {28'd0, frame_start, sync_err, locked, rx_active}, {28'd0, g[23:20]});
        if (g[24]) check("coords", {12'd0, rx_v_cnt, rx_h_cnt}, {12'd0, g[19:0]});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) strobe();
    endtask

    task automatic run_until(input int ln, input int px);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (src_ln == ln && src_px == px) found = 1'b1;
            else strobe();
        end
        check("seek_reached", {31'd0, found}, 32'd1);
    endtask

    task automatic check_stats(input int exp_err, input bit expect_measured);
`ifdef VGA_RX_STATS_EN
        check("err_count", {24'd0, err_count}, 32'(exp_err));
        if (expect_measured) begin
            check("line_len", {21'd0, line_len}, 32'(HT));
            check("frame_lines", {22'd0, frame_lines}, 32'(VT));
        end
`else
        check("err_count_tied", {24'd0, err_count}, 32'd0);
        check("line_len_tied", {21'd0, line_len}, 32'd0);
        check("frame_lines_tied", {22'd0, frame_lines}, 32'd0);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_h"}, {22'd0, rx_h_cnt}, 32'd0);
        check({tag, "_rx_v"}, {22'd0, rx_v_cnt}, 32'd0);
        check({tag, "_flags"}, {28'd0, rx_active, locked, frame_start, sync_err}, 32'd0);
        check({tag, "_state"}, 32'(lock_state), 32'(SEARCH));
        check({tag, "_stats"}, {11'd0, line_len, frame_lines}, 32'd0);
        check({tag, "_err_count"}, {24'd0, err_count}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        src_px = 10; src_ln = 5; src_len = HT; voff = 0; sync_off = 1'b0;
        clear_history();

        // Clock/reset: hold reset, check the reset state, release away from the edge.
        repeat (3) @(negedge mclk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Clean source: lock after the first frame edge plus two full frames, then check coordinates.
        run(5 * FRAME);
        check("locked_clean", {31'd0, locked}, 32'd1);
        check("state_clean", 32'(lock_state), 32'(LOCKED));
        check_stats(0, 1'b1);

        // One short line while locked: single sync_err, drop to SEARCH, relock later.
        run_until(6, 0);
        src_len = HT - 1;
        run(4 * FRAME);
        check("relock_after_short", {31'd0, locked}, 32'd1);
        check_stats(1, 1'b1);

        // Syncs stuck high: hpos runs into saturation, which counts as a bad line.
        run_until(8, 25);
        sync_off = 1'b1;
        run(2100);
        check("stuck_state", 32'(lock_state), 32'(SEARCH));
        check("stuck_flags", {30'd0, locked, rx_active}, 32'd0);
        check_stats(2, 1'b0);
        sync_off = 1'b0;
        src_px = 0; src_ln = 0; src_len = HT; voff = 0;
        run(4 * FRAME);
        check("relock_after_stuck", {31'd0, locked}, 32'd1);

        // Reset pulsed mid-frame while locked: outputs clear at once, then lock is re-acquired.
        run_until(7, 20);
        check("pre_reset_locked", {31'd0, locked}, 32'd1);
        @(negedge mclk);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge mclk);
        @(negedge mclk);
        rst = 1'b1;
        clear_history();
        run(4 * FRAME);
        check("relock_after_reset", {31'd0, locked}, 32'd1);
        check_stats(0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
